// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing for the 5-stage core: load-use bubble, multi-cycle multiply hold in EX, and redirect flush.
// Optional HAZ_PERF_EN adds saturating stall_cycles / flush_count counters.
module pipe_hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int RW      = 5
) (
    input  logic          clk,
    input  logic          rsta,
    input  logic          id_valid,
    input  logic [RW-1:0] id_r1,
    input  logic [RW-1:0] id_r2,
    input  logic          id_use_r1,
    input  logic          id_use_r2,
    input  logic          ex_valid,
    input  logic [RW-1:0] ex_w,
    input  logic          ex_reg_wen,
    input  logic          ex_mem_en,
    input  logic          ex_mem_wen,
    input  logic          ex_mul_en,
    input  logic          redirect,
    output logic          if_allow_in,
    output logic          ex_allow_in,
    output logic          idex_valid_in,
    output logic          ifid_flush,
    output logic          mul_busy,
    output logic          mul_done
`ifdef HAZ_PERF_EN
    ,
    output logic [15:0]   stall_cycles,
    output logic [15:0]   flush_count
`endif
);

    typedef enum logic {RUN, MUL} state_t;

    localparam logic [3:0] LAST = 4'(MUL_LAT - 1);
    localparam bit         LONG = (MUL_LAT > 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       mul_start, at_last, ex_stall;
    logic       load_use, hit1, hit2, redirect_eff;

    always_ff @(posedge clk) begin
        if (rsta) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mul_start = ex_valid & ex_mul_en & (state == RUN);
        at_last   = (state == MUL) && (cnt == LAST);
        ex_stall  = (mul_start & LONG) | ((state == MUL) && !at_last);
        mul_done  = (mul_start & !LONG) | at_last;
        case (state)
            RUN: begin
                if (mul_start && LONG) begin
                    state_nxt = MUL;
                    cnt_nxt   = 4'd1;
                end
            end
            MUL: begin
                if (at_last) begin
                    state_nxt = RUN;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Only a real load into a nonzero register can be consumed too early.
    assign hit1     = id_use_r1 && (id_r1 == ex_w);
    assign hit2     = id_use_r2 && (id_r2 == ex_w);
    assign load_use = id_valid & ex_valid & ex_mem_en & !ex_mem_wen & ex_reg_wen
                      & (ex_w != '0) & (hit1 | hit2);

    // A held EX cannot retire a branch, so redirect waits for the release.
    assign redirect_eff  = redirect & !ex_stall;
    assign ex_allow_in   = !ex_stall;
    assign if_allow_in   = !ex_stall & (!load_use | redirect_eff);
    assign idex_valid_in = id_valid & !load_use & !redirect_eff;
    assign ifid_flush    = redirect_eff;
    assign mul_busy      = (state == MUL);

`ifdef HAZ_PERF_EN
    always_ff @(posedge clk) begin
        if (rsta) begin
            stall_cycles <= 16'd0;
            flush_count  <= 16'd0;
        end else begin
            if (!if_allow_in && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;
            if (ifid_flush && flush_count != 16'hFFFF)
                flush_count <= flush_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: two controllers (MUL_LAT=4 and MUL_LAT=1) share random stimulus and are
// checked against a cycle-count reference model.
module tb_pipe_hazard_ctrl;

    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rsta = 1'b1;
    logic          id_valid = 1'b0, id_use_r1 = 1'b0, id_use_r2 = 1'b0;
    logic [RW-1:0] id_r1 = '0, id_r2 = '0, ex_w = '0;
    logic          ex_valid = 1'b0, ex_reg_wen = 1'b0, ex_mem_en = 1'b0;
    logic          ex_mem_wen = 1'b0, ex_mul_en = 1'b0, redirect = 1'b0;

    logic if_a, exa_a, idv_a, fl_a, busy_a, done_a;
    logic if_b, exa_b, idv_b, fl_b, busy_b, done_b;
`ifdef HAZ_PERF_EN
    logic [15:0] sc_a, fc_a, sc_b, fc_b;
`endif

    pipe_hazard_ctrl #(.MUL_LAT(4), .RW(RW)) dut_a (
        .clk(clk), .rsta(rsta), .id_valid(id_valid), .id_r1(id_r1), .id_r2(id_r2),
        .id_use_r1(id_use_r1), .id_use_r2(id_use_r2), .ex_valid(ex_valid), .ex_w(ex_w),
        .ex_reg_wen(ex_reg_wen), .ex_mem_en(ex_mem_en), .ex_mem_wen(ex_mem_wen),
        .ex_mul_en(ex_mul_en), .redirect(redirect), .if_allow_in(if_a), .ex_allow_in(exa_a),
        .idex_valid_in(idv_a), .ifid_flush(fl_a), .mul_busy(busy_a), .mul_done(done_a)
`ifdef HAZ_PERF_EN
        , .stall_cycles(sc_a), .flush_count(fc_a)
`endif
    );

    pipe_hazard_ctrl #(.MUL_LAT(1), .RW(RW)) dut_b (
        .clk(clk), .rsta(rsta), .id_valid(id_valid), .id_r1(id_r1), .id_r2(id_r2),
        .id_use_r1(id_use_r1), .id_use_r2(id_use_r2), .ex_valid(ex_valid), .ex_w(ex_w),
        .ex_reg_wen(ex_reg_wen), .ex_mem_en(ex_mem_en), .ex_mem_wen(ex_mem_wen),
        .ex_mul_en(ex_mul_en), .redirect(redirect), .if_allow_in(if_b), .ex_allow_in(exa_b),
        .idex_valid_in(idv_b), .ifid_flush(fl_b), .mul_busy(busy_b), .mul_done(done_b)
`ifdef HAZ_PERF_EN
        , .stall_cycles(sc_b), .flush_count(fc_b)
`endif
    );

    always #5 clk = ~clk;

    // Expected bits: {if_allow_in, ex_allow_in, idex_valid_in, ifid_flush, mul_busy, mul_done}
    typedef struct {
        logic [5:0]  a;
        logic [5:0]  b;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;

    // Model state: cycles a multiply still holds EX after the current one.
    int          left_a = 0, left_b = 0;
    logic [15:0] m_sc = 0, m_fc = 0;

    function automatic logic [5:0] model(input int lat, input int left);
        logic lu, stall, done, start, red, ifa, exa, fl, idv;
        lu = id_valid && ex_valid && ex_mem_en && !ex_mem_wen && ex_reg_wen && (ex_w != 0) &&
             ((id_use_r1 && id_r1 == ex_w) || (id_use_r2 && id_r2 == ex_w));
        start = (left == 0) && ex_valid && ex_mul_en;
        if (left > 0) begin
            stall = (left > 1);
            done  = (left == 1);
        end else begin
            stall = start && (lat > 1);
            done  = start && (lat == 1);
        end
        red = redirect && !stall;
        if (stall) begin
            ifa = 0; exa = 0; fl = 0;
        end else if (red) begin
            ifa = 1; exa = 1; fl = 1;
        end else begin
            ifa = !lu; exa = 1; fl = 0;
        end
        idv = id_valid && !lu && !red;
        return {ifa, exa, idv, fl, (left > 0), done};
    endfunction

    function automatic int next_left(input int lat, input int left);
        if (rsta) return 0;
        if (left > 0) return left - 1;
        if (ex_valid && ex_mul_en && lat > 1) return lat - 1;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    // Drive one cycle (called just after a rising edge), record expectation, advance model.
    task automatic cyc(input logic rst, input logic idv, input logic [RW-1:0] r1,
                       input logic [RW-1:0] r2, input logic u1, input logic u2,
                       input logic exv, input logic [RW-1:0] w, input logic rwen,
                       input logic men, input logic mwen, input logic mul, input logic red);
        exp_t e;
        rsta = rst; id_valid = idv; id_r1 = r1; id_r2 = r2; id_use_r1 = u1; id_use_r2 = u2;
        ex_valid = exv; ex_w = w; ex_reg_wen = rwen; ex_mem_en = men; ex_mem_wen = mwen;
        ex_mul_en = mul; redirect = red;
        e.a  = model(4, left_a);
        e.b  = model(1, left_b);
        e.sc = m_sc;
        e.fc = m_fc;
        exp_q.push_back(e);
        @(posedge clk);
        left_a = next_left(4, left_a);
        left_b = next_left(1, left_b);
        if (rst) begin
            m_sc = 0; m_fc = 0;
        end else begin
            if (!e.a[5] && m_sc != 16'hFFFF) m_sc = m_sc + 1;
            if (e.a[2] && m_fc != 16'hFFFF) m_fc = m_fc + 1;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("a_if_allow_in",   16'(if_a),   16'(e.a[5]));
            chk("a_ex_allow_in",   16'(exa_a),  16'(e.a[4]));
            chk("a_idex_valid_in", 16'(idv_a),  16'(e.a[3]));
            chk("a_ifid_flush",    16'(fl_a),   16'(e.a[2]));
            chk("a_mul_busy",      16'(busy_a), 16'(e.a[1]));
            chk("a_mul_done",      16'(done_a), 16'(e.a[0]));
            chk("b_if_allow_in",   16'(if_b),   16'(e.b[5]));
            chk("b_ex_allow_in",   16'(exa_b),  16'(e.b[4]));
            chk("b_idex_valid_in", 16'(idv_b),  16'(e.b[3]));
            chk("b_ifid_flush",    16'(fl_b),   16'(e.b[2]));
            chk("b_mul_busy",      16'(busy_b), 16'(e.b[1]));
            chk("b_mul_done",      16'(done_b), 16'(e.b[0]));
`ifdef HAZ_PERF_EN
            chk("a_stall_cycles",  sc_a, e.sc);
            chk("a_flush_count",   fc_a, e.fc);
`endif
        end
    end

    initial begin
        // Bring both controllers to a known state before anything is checked.
        repeat (2) @(posedge clk);
        #1;
        // Reset held two cycles during a multiply at cnt=2, then idle with ex_valid=0.
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Load-use on r5, then the load has moved on.
        cyc(0, 1, 5, 0, 1, 0, 1, 5, 1, 1, 0, 0, 0);
        cyc(0, 1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        // No-hazard cases: load to r0, store to r5, unused r2.
        cyc(0, 1, 0, 0, 1, 1, 1, 0, 1, 1, 0, 0, 0);
        cyc(0, 1, 5, 5, 1, 1, 1, 5, 1, 1, 1, 0, 0);
        cyc(0, 1, 0, 5, 0, 0, 1, 5, 1, 1, 0, 0, 0);
        // Back-to-back multiplies: second one issued the cycle after done.
        cyc(0, 1, 1, 2, 1, 1, 1, 3, 1, 0, 0, 1, 0);
        cyc(0, 1, 1, 2, 1, 1, 1, 3, 1, 0, 0, 1, 1);
        repeat (2) cyc(0, 1, 1, 2, 1, 1, 1, 3, 1, 0, 0, 1, 0);
        repeat (4) cyc(0, 1, 1, 2, 1, 1, 1, 3, 1, 0, 0, 1, 0);
        // Redirect together with load-use.
        cyc(0, 1, 5, 0, 1, 0, 1, 5, 1, 1, 0, 0, 1);
        // Randomised traffic over a small register set so hazards are frequent.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) == 0), $urandom_range(0, 3) != 0,
                RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0,
                RW'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 9) == 0);
        end
`ifdef HAZ_PERF_EN
        // Long load-use run to saturate the stall counter.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 70000; i++)
            cyc(0, 1, 5, 0, 1, 0, 1, 5, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            fails++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
